// File: rtl/cordic_spi_master.sv
// SPI mode-0 initiator for the cordic_fsm responder: sends one angle word, waits, then reads cos/sin.
// Optional miso 2-flop synchronizer enabled by defining CORDIC_SPI_MISO_SYNC_EN.
module cordic_spi_master #(
  parameter int unsigned DATA_WIDTH_CORDIC = 16,
  parameter int unsigned DATA_WIDTH_SPI    = 8,
  parameter int unsigned CLK_DIV           = 4,
  parameter int unsigned GAP_CYCLES        = 64
) (
  input  logic                         i_clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH_CORDIC-1:0] i_angle,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic [DATA_WIDTH_CORDIC-1:0] o_cos,
  output logic [DATA_WIDTH_CORDIC-1:0] o_sin,
  output logic                         o_valid,
  output logic                         o_busy,
  output logic                         sclk,
  output logic                         mosi,
  input  logic                         miso,
  output logic                         cs_n
);

  localparam int unsigned DW      = DATA_WIDTH_CORDIC;
  localparam int unsigned NBYTES  = DATA_WIDTH_CORDIC / DATA_WIDTH_SPI;
  localparam int unsigned CNT_MAX = (GAP_CYCLES > 2 * CLK_DIV) ? GAP_CYCLES : 2 * CLK_DIV;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned BW      = (DATA_WIDTH_SPI > 1) ? $clog2(DATA_WIDTH_SPI) : 1;
  localparam int unsigned YW      = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [CW-1:0] L_HALF      = CW'(CLK_DIV);
  localparam logic [CW-1:0] L_HALF_M1   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] L_BIT_M1    = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] L_GAP_M1    = CW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0] L_BIT_LAST  = BW'(DATA_WIDTH_SPI - 1);
  localparam logic [YW-1:0] L_BYTE_LAST = YW'(NBYTES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_TX      = 3'd2;
  localparam logic [2:0] S_GAP     = 3'd3;
  localparam logic [2:0] S_RX      = 3'd4;
  localparam logic [2:0] S_HOLD    = 3'd5;
  localparam logic [2:0] S_RECOVER = 3'd6;

  if (CLK_DIV < 2) begin : g_chk_div
    $error("cordic_spi_master: CLK_DIV must be >= 2");
  end
  if (GAP_CYCLES < 1) begin : g_chk_gap
    $error("cordic_spi_master: GAP_CYCLES must be >= 1");
  end
  if ((DATA_WIDTH_CORDIC % DATA_WIDTH_SPI) != 0) begin : g_chk_width
    $error("cordic_spi_master: DATA_WIDTH_CORDIC must be a multiple of DATA_WIDTH_SPI");
  end

  logic [2:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_bit;
  logic [YW-1:0]     r_byte;
  logic              r_word;
  logic [DW-1:0]     r_tx_sh;
  logic [2*DW-1:0]   r_rx_sh;
  logic              r_sclk;
  logic              r_mosi;
  logic              r_cs_n;
  logic              r_ready;
  logic              r_valid;
  logic [DW-1:0]     r_cos;
  logic [DW-1:0]     r_sin;

  logic [2:0]        w_state_d;
  logic [CW-1:0]     w_cnt_d;
  logic [BW-1:0]     w_bit_d;
  logic [YW-1:0]     w_byte_d;
  logic              w_word_d;
  logic [DW-1:0]     w_tx_sh_d;
  logic [2*DW-1:0]   w_rx_sh_d;
  logic              w_valid_d;
  logic [DW-1:0]     w_cos_d;
  logic [DW-1:0]     w_sin_d;
  logic              w_sclk_d;
  logic              w_mosi_d;
  logic              w_cs_n_d;
  logic              w_ready_d;
  logic [BW-1:0]     w_bit_nx;
  logic [YW-1:0]     w_byte_nx;
  logic              w_accept;
  logic              w_bit_end;
  logic              w_last_bit;
  logic              w_sample;
  logic              w_miso;

  assign w_accept   = i_valid & r_ready;
  assign w_bit_end  = (r_cnt == L_BIT_M1);
  assign w_last_bit = (r_bit == L_BIT_LAST) && (r_byte == L_BYTE_LAST);

`ifdef CORDIC_SPI_MISO_SYNC_EN
  logic r_miso_s1;
  logic r_miso_s2;

  if (CLK_DIV < 3) begin : g_chk_sync
    $error("cordic_spi_master: CLK_DIV must be >= 3 with the miso synchronizer");
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      r_miso_s1 <= 1'b0;
      r_miso_s2 <= 1'b0;
    end else begin
      r_miso_s1 <= miso;
      r_miso_s2 <= r_miso_s1;
    end
  end

  // Sample late in the high phase so the synchronizer has caught up with the responder.
  assign w_miso   = r_miso_s2;
  assign w_sample = (r_state == S_RX) && w_bit_end;
`else
  assign w_miso   = miso;
  assign w_sample = (r_state == S_RX) && (r_cnt == L_HALF_M1);
`endif

  // Bit counter wraps within a byte; byte counter wraps within a word.
  always_comb begin
    w_bit_nx  = r_bit + 1'b1;
    w_byte_nx = r_byte;
    if (r_bit == L_BIT_LAST) begin
      w_bit_nx  = '0;
      w_byte_nx = (r_byte == L_BYTE_LAST) ? '0 : r_byte + 1'b1;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt + 1'b1;
    w_bit_d   = r_bit;
    w_byte_d  = r_byte;
    w_word_d  = r_word;
    w_tx_sh_d = r_tx_sh;
    w_rx_sh_d = r_rx_sh;
    w_valid_d = 1'b0;
    w_cos_d   = r_cos;
    w_sin_d   = r_sin;
    case (r_state)
      S_IDLE: begin
        w_cnt_d = '0;
        if (w_accept) begin
          w_state_d = S_SETUP;
          w_tx_sh_d = i_angle;
          w_bit_d   = '0;
          w_byte_d  = '0;
          w_word_d  = 1'b0;
        end
      end
      S_SETUP: begin
        if (r_cnt == L_HALF_M1) begin
          w_state_d = S_TX;
          w_cnt_d   = '0;
        end
      end
      S_TX: begin
        if (w_bit_end) begin
          w_cnt_d   = '0;
          w_tx_sh_d = r_tx_sh << 1;
          w_bit_d   = w_bit_nx;
          w_byte_d  = w_byte_nx;
          if (w_last_bit) begin
            w_state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (r_cnt == L_GAP_M1) begin
          w_state_d = S_RX;
          w_cnt_d   = '0;
        end
      end
      S_RX: begin
        if (w_sample) begin
          w_rx_sh_d = {r_rx_sh[2*DW-2:0], w_miso};
        end
        if (w_bit_end) begin
          w_cnt_d  = '0;
          w_bit_d  = w_bit_nx;
          w_byte_d = w_byte_nx;
          if (w_last_bit) begin
            w_word_d = ~r_word;
            if (r_word) begin
              w_state_d = S_HOLD;
            end
          end
        end
      end
      S_HOLD: begin
        if (r_cnt == L_HALF_M1) begin
          w_state_d = S_RECOVER;
          w_cnt_d   = '0;
          w_valid_d = 1'b1;
          w_cos_d   = r_rx_sh[2*DW-1:DW];
          w_sin_d   = r_rx_sh[DW-1:0];
        end
      end
      S_RECOVER: begin
        if (r_cnt == L_HALF_M1) begin
          w_state_d = S_IDLE;
          w_cnt_d   = '0;
        end
      end
      default: begin
        w_state_d = S_IDLE;
        w_cnt_d   = '0;
      end
    endcase
  end

  // Pin values are registered from the next state so every output is glitch-free.
  always_comb begin
    w_sclk_d  = ((w_state_d == S_TX) || (w_state_d == S_RX)) && (w_cnt_d >= L_HALF);
    w_mosi_d  = ((w_state_d == S_SETUP) || (w_state_d == S_TX)) ? w_tx_sh_d[DW-1] : 1'b0;
    w_cs_n_d  = (w_state_d == S_IDLE) || (w_state_d == S_RECOVER);
    w_ready_d = (w_state_d == S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_word  <= 1'b0;
      r_tx_sh <= '0;
      r_rx_sh <= '0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_cos   <= '0;
      r_sin   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_bit   <= w_bit_d;
      r_byte  <= w_byte_d;
      r_word  <= w_word_d;
      r_tx_sh <= w_tx_sh_d;
      r_rx_sh <= w_rx_sh_d;
      r_sclk  <= w_sclk_d;
      r_mosi  <= w_mosi_d;
      r_cs_n  <= w_cs_n_d;
      r_ready <= w_ready_d;
      r_valid <= w_valid_d;
      r_cos   <= w_cos_d;
      r_sin   <= w_sin_d;
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_cos   = r_cos;
  assign o_sin   = r_sin;
  assign o_busy  = (r_state != S_IDLE);
  assign sclk    = r_sclk;
  assign mosi    = r_mosi;
  assign cs_n    = r_cs_n;

endmodule

// File: tb/tb_cordic_spi_master.sv
// Bench for cordic_spi_master: responder model on the SPI pins plus a latency-aware scoreboard.
module tb_cordic_spi_master;

  localparam int DW  = 16;
  localparam int CD  = 4;
  localparam int GAP = 64;
  localparam int LAT = 1 + CD * (2 + 6 * DW) + GAP;

  typedef struct {
    logic [15:0] angle;
    logic [15:0] cos_v;
    logic [15:0] sin_v;
  } vec_t;

  typedef struct {
    logic [15:0] angle;
    logic [15:0] cos_v;
    logic [15:0] sin_v;
    int          acc_cyc;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [15:0] i_angle = '0;
  logic        miso = 1'b0;
  logic        o_ready, o_valid, o_busy, sclk, mosi, cs_n;
  logic [15:0] o_cos, o_sin;

  vec_t tbl[8];
  sb_t  sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   n_vld = 0;

  always #5 clk = ~clk;

  cordic_spi_master #(
    .DATA_WIDTH_CORDIC(DW),
    .DATA_WIDTH_SPI   (8),
    .CLK_DIV          (CD),
    .GAP_CYCLES       (GAP)
  ) dut (
    .i_clk  (clk),
    .rst    (rst),
    .i_angle(i_angle),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_cos  (o_cos),
    .o_sin  (o_sin),
    .o_valid(o_valid),
    .o_busy (o_busy),
    .sclk   (sclk),
    .mosi   (mosi),
    .miso   (miso),
    .cs_n   (cs_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] resp_lookup(input logic [15:0] a);
    foreach (tbl[i]) if (tbl[i].angle == a) return {tbl[i].cos_v, tbl[i].sin_v};
    return 32'hDEAD_BEEF;
  endfunction

  // Responder model and scoreboard monitor, sampled 1ns after each rising edge.
  initial begin
    logic        prev_ready, prev_cs_n, prev_sclk, prev_valid, have_rise;
    logic [15:0] cap;
    logic [31:0] resp_sh;
    int          rise_cnt, rise_cyc;
    sb_t         e;
    prev_ready = 0; prev_cs_n = 1; prev_sclk = 0; prev_valid = 0; have_rise = 0;
    cap = '0; resp_sh = '0; rise_cnt = 0; rise_cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        sb_q.delete();
        rise_cnt = 0; miso = 1'b0;
        prev_ready = 0; prev_cs_n = 1; prev_sclk = 0; prev_valid = 0;
        continue;
      end
      if (i_valid && prev_ready) begin
        e.angle = i_angle;
        {e.cos_v, e.sin_v} = resp_lookup(i_angle);
        e.acc_cyc = cyc;
        sb_q.push_back(e);
        n_acc++;
      end
      if (prev_cs_n && !cs_n) begin
        if (have_rise) check("cs_n high time >= CLK_DIV", 32'(cyc - rise_cyc >= CD), 32'd1);
        rise_cnt = 0;
        cap = '0;
      end
      if (!cs_n && sclk && !prev_sclk) begin
        rise_cnt++;
        if (rise_cnt <= DW) cap = {cap[14:0], mosi};
        if (rise_cnt == DW) begin
          resp_sh = resp_lookup(cap);
          miso = resp_sh[31];
        end
      end
      if (!cs_n && !sclk && prev_sclk && rise_cnt > DW) begin
        resp_sh = resp_sh << 1;
        miso = resp_sh[31];
      end
      if (!prev_cs_n && cs_n) begin
        have_rise = 1;
        rise_cyc = cyc;
      end
      if (prev_valid) check("o_valid one-cycle pulse", 32'(o_valid), 32'd0);
      if (o_valid) begin
        n_vld++;
        if (sb_q.size() == 0) begin
          check("o_valid without accepted request", 32'(o_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("o_cos", 32'(o_cos), 32'(e.cos_v));
          check("o_sin", 32'(o_sin), 32'(e.sin_v));
          check("latency", 32'(cyc - e.acc_cyc + 1), 32'(LAT));
          check("mosi payload", 32'(cap), 32'(e.angle));
          check("sclk rises", 32'(rise_cnt), 32'(3 * DW));
        end
      end
      prev_ready = o_ready;
      prev_cs_n  = cs_n;
      prev_sclk  = sclk;
      prev_valid = o_valid;
    end
  end

  task automatic send(input logic [15:0] a);
    int a0, t;
    @(negedge clk);
    i_valid = 1'b1;
    i_angle = a;
    a0 = n_acc;
    t = 0;
    while (n_acc == a0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    i_valid = 1'b0;
    check("accept within bound", 32'(n_acc != a0), 32'd1);
  endtask

  task automatic wait_done(input int max);
    int t;
    t = 0;
    @(negedge clk);
    while ((sb_q.size() != 0 || !o_ready) && t < max) begin
      @(negedge clk);
      t++;
    end
    check("completion within bound", 32'(t < max), 32'd1);
  endtask

  initial begin
    int v0, a0, t;
    tbl[0] = '{16'h2000, 16'h4DBA, 16'h4DBA};
    tbl[1] = '{16'h0000, 16'h7FFF, 16'h0000};
    tbl[2] = '{16'hC000, 16'h0000, 16'h8001};
    tbl[3] = '{16'h4000, 16'h0000, 16'h7FFF};
    tbl[4] = '{16'h8000, 16'h8001, 16'h0000};
    tbl[5] = '{16'h1234, 16'h7A3C, 16'h258C};
    tbl[6] = '{16'hFFFF, 16'hAAAA, 16'h5555};
    tbl[7] = '{16'h0001, 16'h8000, 16'h7FFE};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset cs_n", 32'(cs_n), 32'd1);
    check("reset sclk", 32'(sclk), 32'd0);
    check("reset mosi", 32'(mosi), 32'd0);
    check("reset o_valid", 32'(o_valid), 32'd0);
    check("reset o_busy", 32'(o_busy), 32'd0);
    check("reset o_cos", 32'(o_cos), 32'd0);
    check("reset o_sin", 32'(o_sin), 32'd0);
    check("o_ready low in reset", 32'(o_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("o_ready after reset", 32'(o_ready), 32'd1);

    // Table-driven single operations
    foreach (tbl[i]) begin
      send(tbl[i].angle);
      wait_done(1000);
      check("held o_cos", 32'(o_cos), 32'(tbl[i].cos_v));
      check("held o_sin", 32'(o_sin), 32'(tbl[i].sin_v));
    end

    // Back-to-back with i_valid held high
    @(negedge clk);
    i_valid = 1'b1;
    i_angle = 16'h0000;
    a0 = n_acc;
    t = 0;
    while (n_acc == a0 && t < 2000) begin @(negedge clk); t++; end
    i_angle = 16'hC000;
    t = 0;
    while (n_acc < a0 + 2 && t < 2000) begin @(negedge clk); t++; end
    i_valid = 1'b0;
    check("back-to-back accepts", 32'(n_acc - a0), 32'd2);
    wait_done(1000);
    check("b2b final o_cos", 32'(o_cos), 32'h0000);
    check("b2b final o_sin", 32'(o_sin), 32'h8001);

    // Request while busy is ignored
    v0 = n_vld;
    a0 = n_acc;
    send(16'h2000);
    repeat (100) @(negedge clk);
    i_valid = 1'b1;
    i_angle = 16'h1234;
    @(negedge clk);
    i_valid = 1'b0;
    wait_done(1000);
    repeat (20) @(negedge clk);
    check("busy ignore o_valid count", 32'(n_vld - v0), 32'd1);
    check("busy ignore accept count", 32'(n_acc - a0), 32'd1);
    check("busy ignore o_cos", 32'(o_cos), 32'h4DBA);

    // Mid-operation reset
    v0 = n_vld;
    send(16'h4000);
    repeat (200) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid reset cs_n", 32'(cs_n), 32'd1);
    check("mid reset sclk", 32'(sclk), 32'd0);
    check("mid reset mosi", 32'(mosi), 32'd0);
    check("mid reset o_valid", 32'(o_valid), 32'd0);
    check("mid reset o_busy", 32'(o_busy), 32'd0);
    check("mid reset o_cos", 32'(o_cos), 32'd0);
    check("mid reset o_sin", 32'(o_sin), 32'd0);
    rst = 1'b0;
    repeat (600) @(negedge clk);
    check("no o_valid after mid reset", 32'(n_vld - v0), 32'd0);
    send(16'h8000);
    wait_done(1000);
    check("post reset o_cos", 32'(o_cos), 32'h8001);
    check("post reset o_sin", 32'(o_sin), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
